// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive frame controller:
// FSM states, preamble/SFD bytes, CRC-32 constants and status bit positions.
package gmii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam int FRAME_LEN_W  = 11;
    localparam int ERR_W        = 4;
    localparam int ERR_RXER     = 0;
    localparam int ERR_OVERSIZE = 1;
    localparam int ERR_RUNT     = 2;
    localparam int ERR_CRC      = 3;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/gmii_rx_crc32.sv
// Byte-wide CRC-32 accumulator with synchronous clear; only instantiated by
// gmii_rx_frame_ctrl when RX_CRC_CHECK_EN is defined.
module gmii_rx_crc32
    import gmii_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// GMII receive framer: strips preamble/SFD, emits frame bytes with sof/eof and
// per-frame status. Define RX_CRC_CHECK_EN to build the FCS check.
module gmii_rx_frame_ctrl
    import gmii_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                   gmii_rx_clk,
    input  logic                   reset,
    input  logic [7:0]             gmii_rxd,
    input  logic                   gmii_rxdv,
    input  logic                   gmii_rxer,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic                   frame_done,
    output logic [FRAME_LEN_W-1:0] frame_len,
    output logic [ERR_W-1:0]       frame_err,
    output logic [15:0]            good_cnt,
    output logic [15:0]            bad_cnt
);

    localparam logic [FRAME_LEN_W-1:0] LEN_MAX = FRAME_LEN_W'(MAX_FRAME_LEN);
    localparam logic [FRAME_LEN_W-1:0] LEN_SAT = FRAME_LEN_W'(MAX_FRAME_LEN + 1);
    localparam logic [FRAME_LEN_W-1:0] LEN_MIN = FRAME_LEN_W'(MIN_FRAME_LEN);

    rx_state_t              state, state_next;
    logic                   dv_d;
    logic [3:0]             pre_cnt;
    logic [7:0]             hold;
    logic                   hold_vld;
    logic                   first_pend;
    logic [FRAME_LEN_W-1:0] len_cnt;
    logic                   rxer_seen;
    logic                   done_pend;
    logic                   crc_err;
    logic [ERR_W-1:0]       err_final;

    logic pre_load, pre_inc, start_frame, take_byte, emit, emit_eof, finish;

    // NOTE: dv_d is kept out of reset so it follows rxdv throughout reset; a frame
    // already streaming when reset releases then sees dv_d=1 and lands in DROP.
    always_ff @(posedge gmii_rx_clk) begin
        dv_d <= gmii_rxdv;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    always_comb begin
        state_next  = state;
        pre_load    = 1'b0;
        pre_inc     = 1'b0;
        start_frame = 1'b0;
        take_byte   = 1'b0;
        emit        = 1'b0;
        emit_eof    = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (gmii_rxdv) begin
                    if (!dv_d && gmii_rxd == PREAMBLE_BYTE) begin
                        state_next = PREAMBLE;
                        pre_load   = 1'b1;
                    end else begin
                        state_next = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rxdv) begin
                    state_next = IDLE;
                end else if (gmii_rxd == PREAMBLE_BYTE) begin
                    if (pre_cnt >= 4'd7) begin
                        state_next = DROP;
                    end else begin
                        pre_inc = 1'b1;
                    end
                end else if (gmii_rxd == SFD_BYTE && pre_cnt >= 4'd1 && pre_cnt <= 4'd7) begin
                    state_next  = DATA;
                    start_frame = 1'b1;
                end else begin
                    state_next = DROP;
                end
            end
            DATA: begin
                if (gmii_rxdv) begin
                    take_byte = 1'b1;
                    if (hold_vld) begin
                        emit = 1'b1;
                        // Arrival of byte MAX+1 closes the frame on byte MAX.
                        if (len_cnt == LEN_MAX) begin
                            emit_eof   = 1'b1;
                            finish     = 1'b1;
                            state_next = DROP;
                        end
                    end
                end else begin
                    state_next = IDLE;
                    if (hold_vld) begin
                        emit     = 1'b1;
                        emit_eof = 1'b1;
                        finish   = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!gmii_rxdv) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RX_CRC_CHECK_EN
    logic [31:0] crc_reg;

    gmii_rx_crc32 u_crc (
        .clk   (gmii_rx_clk),
        .reset (reset),
        .clear (start_frame),
        .en    (take_byte),
        .data  (gmii_rxd),
        .crc   (crc_reg)
    );

    assign crc_err = (crc_reg != CRC_RESIDUE);
`else
    assign crc_err = 1'b0;
`endif

    // Frame counters and crc stay frozen until the next SFD, so status can be formed a cycle after eof.
    always_comb begin
        err_final               = '0;
        err_final[ERR_RXER]     = rxer_seen;
        err_final[ERR_OVERSIZE] = (len_cnt == LEN_SAT);
        err_final[ERR_RUNT]     = (len_cnt < LEN_MIN);
        err_final[ERR_CRC]      = crc_err;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_err  <= '0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            pre_cnt    <= '0;
            hold       <= '0;
            hold_vld   <= 1'b0;
            first_pend <= 1'b0;
            len_cnt    <= '0;
            rxer_seen  <= 1'b0;
            done_pend  <= 1'b0;
        end else begin
            out_valid <= emit;
            out_sof   <= emit & first_pend;
            out_eof   <= emit_eof;
            out_data  <= emit ? hold : 8'h00;

            if (pre_load) begin
                pre_cnt <= 4'd1;
            end else if (pre_inc) begin
                pre_cnt <= pre_cnt + 4'd1;
            end

            if (start_frame) begin
                hold_vld   <= 1'b0;
                first_pend <= 1'b1;
                len_cnt    <= '0;
                rxer_seen  <= 1'b0;
            end else if (state == DATA) begin
                hold_vld <= take_byte & ~finish;
                if (take_byte) begin
                    hold <= gmii_rxd;
                    if (len_cnt != LEN_SAT) begin
                        len_cnt <= len_cnt + FRAME_LEN_W'(1);
                    end
                end
                if (gmii_rxer) begin
                    rxer_seen <= 1'b1;
                end
                if (emit) begin
                    first_pend <= 1'b0;
                end
            end

            done_pend  <= finish;
            frame_done <= done_pend;
            if (done_pend) begin
                frame_len <= len_cnt;
                frame_err <= err_final;
                if (err_final == '0) begin
                    if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                end else begin
                    if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// Randomized self-checking bench for gmii_rx_frame_ctrl; expected bytes and status
// come from a frame-level model (byte queues plus table-driven CRC-32).
module tb_gmii_rx_frame_ctrl;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rxd;
    logic        rxdv;
    logic        rxer;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic        frame_done;
    logic [10:0] frame_len;
    logic [3:0]  frame_err;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    gmii_rx_frame_ctrl #(
        .MIN_FRAME_LEN (MIN_LEN),
        .MAX_FRAME_LEN (MAX_LEN)
    ) dut (
        .gmii_rx_clk (clk),
        .reset       (reset),
        .gmii_rxd    (rxd),
        .gmii_rxdv   (rxdv),
        .gmii_rxer   (rxer),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .frame_err   (frame_err),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } ob_t;

    typedef struct packed {
        logic [10:0] len;
        logic [3:0]  err;
        logic [15:0] good;
        logic [15:0] bad;
    } st_t;

    ob_t         exp_q[$];
    st_t         st_q[$];
    int          sof_cyc_q[$];
    logic [7:0]  frm [2048];
    logic [31:0] crc_tab [256];
    int          good_m;
    int          bad_m;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ frm[i]];
        return ~c;
    endfunction

    // Random payload followed by its FCS, little-endian; corrupt flips the last FCS byte.
    task automatic make_frame(input int n, input bit corrupt);
        logic [31:0] fcs;
        for (int i = 0; i < n - 4; i++) frm[i] = 8'($urandom);
        fcs = ref_crc(n - 4);
        frm[n-4] = fcs[7:0];
        frm[n-3] = fcs[15:8];
        frm[n-2] = fcs[23:16];
        frm[n-1] = fcs[31:24];
        if (corrupt) frm[n-1] = frm[n-1] ^ 8'hFF;
    endtask

    task automatic model_frame(input int n, input int rxer_idx);
        int  out_n;
        int  l;
        st_t s;
        out_n = (n > MAX_LEN) ? MAX_LEN : n;
        l     = (n > MAX_LEN) ? MAX_LEN + 1 : n;
        for (int i = 0; i < out_n; i++)
            exp_q.push_back('{d: frm[i], sof: (i == 0), eof: (i == out_n - 1)});
        s     = '0;
        s.len = 11'(l);
        s.err[0] = (rxer_idx >= 0 && rxer_idx < l);
        s.err[1] = (n > MAX_LEN);
        s.err[2] = (l < MIN_LEN);
`ifdef RX_CRC_CHECK_EN
        s.err[3] = (ref_crc(l - 4) != {frm[l-1], frm[l-2], frm[l-3], frm[l-4]});
`endif
        if (s.err == 4'b0000) begin
            if (good_m < 65535) good_m++;
        end else begin
            if (bad_m < 65535) bad_m++;
        end
        s.good = 16'(good_m);
        s.bad  = 16'(bad_m);
        st_q.push_back(s);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        rxdv = dv;
        rxd  = d;
        rxer = er;
        @(negedge clk);
    endtask

    task automatic send(input int pre_n, input int n, input int rxer_idx, input int gap);
        for (int i = 0; i < pre_n; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == 0) sof_cyc_q.push_back(cyc);
            drive(1'b1, frm[i], i == rxer_idx);
        end
        for (int i = 0; i < gap; i++) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic run_frame(input int n, input int pre_n, input int rxer_idx, input int gap, input bit corrupt);
        make_frame(n, corrupt);
        model_frame(n, rxer_idx);
        send(pre_n, n, rxer_idx, gap);
    endtask

    // Output monitor, sampled on the falling edge.
    ob_t  mon_e;
    st_t  mon_s;
    logic last_eof = 1'b0;
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.d));
                check("out_sof", 32'(out_sof), 32'(mon_e.sof));
                check("out_eof", 32'(out_eof), 32'(mon_e.eof));
                if (out_sof === 1'b1 && sof_cyc_q.size() > 0)
                    check("latency", 32'(cyc - sof_cyc_q.pop_front()), 32'd2);
            end
        end else if (out_sof === 1'b1 || out_eof === 1'b1) begin
            check("flag_no_valid", 32'({out_sof, out_eof}), 32'd0);
        end
        if (frame_done === 1'b1 || last_eof) check("done_after_eof", 32'(frame_done), 32'(last_eof));
        last_eof = (out_valid === 1'b1) && (out_eof === 1'b1);
        if (frame_done === 1'b1) begin
            if (st_q.size() == 0) begin
                check("extra_done", 32'(frame_done), 32'd0);
            end else begin
                mon_s = st_q.pop_front();
                check("frame_len", 32'(frame_len), 32'(mon_s.len));
                check("frame_err", 32'(frame_err), 32'(mon_s.err));
                check("good_cnt", 32'(good_cnt), 32'(mon_s.good));
                check("bad_cnt", 32'(bad_cnt), 32'(mon_s.bad));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 32'(i);
            for (int b = 0; b < 8; b++) v = v[0] ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
            crc_tab[i] = v;
        end
        good_m = 0;
        bad_m  = 0;
        reset  = 1'b1;
        rxdv   = 1'b0;
        rxd    = 8'h00;
        rxer   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({out_valid, out_sof, out_eof, frame_done, out_data, frame_len, frame_err}), 32'd0);
        check("rst_cnts", {good_cnt, bad_cnt}, 32'd0);
        reset = 1'b0;
        repeat (2) drive(1'b0, 8'h00, 1'b0);

        run_frame(64, 7, -1, 1, 1'b0);    // good minimum frame
        run_frame(64, 7, -1, 1, 1'b1);    // bad FCS
        run_frame(60, 7, -1, 2, 1'b0);    // runt
        run_frame(1600, 7, -1, 1, 1'b0);  // oversize, then back-to-back
        run_frame(100, 7, -1, 1, 1'b0);
        run_frame(64, 7, 19, 1, 1'b0);    // rxer on byte 20

        // Broken preamble: dropped silently.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        run_frame(70, 7, -1, 3, 1'b0);

        // Preamble cut short by rxdv falling.
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        run_frame(64, 1, -1, 2, 1'b0);

        for (int r = 0; r < 24; r++) begin
            int n;
            int rx;
            n  = (r % 6 == 5) ? int'($urandom_range(20, 63)) : int'($urandom_range(64, 300));
            rx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_frame(n, int'($urandom_range(1, 7)), rx, int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));
        end

        // Reset while data byte 30 is on the wire; rxdv stays high after release.
        make_frame(80, 1'b0);
        for (int i = 0; i < 29; i++) exp_q.push_back('{d: frm[i], sof: (i == 0), eof: 1'b0});
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 80; i++) begin
            if (i == 0) sof_cyc_q.push_back(cyc);
            if (i >= 31 && i <= 34) begin
                check("midrst_outs", 32'({out_valid, out_sof, out_eof, frame_done, out_data, frame_len, frame_err}), 32'd0);
                check("midrst_cnts", {good_cnt, bad_cnt}, 32'd0);
            end
            if (i == 30) begin
                good_m = 0;
                bad_m  = 0;
            end
            reset = (i >= 30 && i < 34);
            drive(1'b1, frm[i], 1'b0);
        end
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        run_frame(64, 7, -1, 2, 1'b0);

        repeat (10) drive(1'b0, 8'h00, 1'b0);
        check("exp_bytes_left", 32'(exp_q.size()), 32'd0);
        check("exp_status_left", 32'(st_q.size()), 32'd0);
        check("final_good", 32'(good_cnt), 32'(good_m));
        check("final_bad", 32'(bad_cnt), 32'(bad_m));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
